// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants and receiver state encoding
package uart_pkg;

   localparam int W5Frequency      = 6_250_000;
   localparam int baudRate         = 230400;
   localparam int samplingInterval = W5Frequency / baudRate;
   localparam int bitCycles        = samplingInterval + 1;
   localparam int halfBit          = bitCycles / 2;

   // Counter compare values sized to the 5-bit bit counter
   localparam logic [4:0] BIT_LAST  = 5'(bitCycles - 1);
   localparam logic [4:0] HALF_LAST = 5'(halfBit - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with selectable reset value
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two back-to-back flops give the first stage a full cycle to resolve
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 LSB-first UART receiver with glitch rejection and framing check
module uart_receiver
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       RxD,
   output logic [7:0] RxData,
   output logic       dataValid,
   output logic       frameError,
   output logic       isBusy
);

   logic       rxS;
   rx_state_t  state_q;
   logic [4:0] bitCnt_q;
   logic [2:0] bitIdx_q;
   logic [7:0] shiftReg_q;
   logic [7:0] RxData_q;
   logic       dataValid_q;
   logic       frameError_q;
   logic       isBusy_q;
   logic [4:0] bitCnt_d;

   // Idle line is high, so the synchronizer comes out of reset at 1
   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_rx_sync (
      .clk  (clk),
      .reset(reset),
      .d_i  (RxD),
      .q_o  (rxS)
   );

   assign bitCnt_d = bitCnt_q + 5'd1;

   // Frame sequencing: start-bit centre check, eight data samples, stop check
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         bitCnt_q     <= 5'd0;
         bitIdx_q     <= 3'd0;
         shiftReg_q   <= 8'd0;
         RxData_q     <= 8'd0;
         dataValid_q  <= 1'b0;
         frameError_q <= 1'b0;
         isBusy_q     <= 1'b0;
      end else begin
         dataValid_q  <= 1'b0;
         frameError_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxS) begin
                  bitCnt_q <= 5'd0;
                  isBusy_q <= 1'b1;
                  state_q  <= START;
               end
            end
            START: begin
               if (bitCnt_q == HALF_LAST) begin
                  if (rxS) begin
                     // Line went back high before mid start bit: glitch
                     isBusy_q <= 1'b0;
                     state_q  <= IDLE;
                  end else begin
                     bitCnt_q <= 5'd0;
                     bitIdx_q <= 3'd0;
                     state_q  <= DATA;
                  end
               end else begin
                  bitCnt_q <= bitCnt_d;
               end
            end
            DATA: begin
               if (bitCnt_q == BIT_LAST) begin
                  shiftReg_q <= {rxS, shiftReg_q[7:1]};
                  bitCnt_q   <= 5'd0;
                  bitIdx_q   <= bitIdx_q + 3'd1;
                  if (bitIdx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  bitCnt_q <= bitCnt_d;
               end
            end
            STOP: begin
               if (bitCnt_q == BIT_LAST) begin
                  bitCnt_q <= 5'd0;
                  if (rxS) begin
                     // Leave mid stop bit so an immediate next start edge is caught
                     RxData_q    <= shiftReg_q;
                     dataValid_q <= 1'b1;
                     isBusy_q    <= 1'b0;
                     state_q     <= IDLE;
                  end else begin
                     frameError_q <= 1'b1;
                     state_q      <= WAIT_IDLE;
                  end
               end else begin
                  bitCnt_q <= bitCnt_d;
               end
            end
            WAIT_IDLE: begin
               // A held-low line (break) must not look like new start bits
               if (rxS) begin
                  isBusy_q <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               isBusy_q <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign RxData     = RxData_q;
   assign dataValid  = dataValid_q;
   assign frameError = frameError_q;
   assign isBusy     = isBusy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

   localparam int BIT = 28;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       RxD = 1'b1;
   logic [7:0] RxData;
   logic       dataValid;
   logic       frameError;
   logic       isBusy;

   int checks = 0;
   int passed = 0;

   int         cyc = 0;
   logic [7:0] rx_q[$];
   int         dv_cyc[$];
   int         fe_cnt = 0;
   int         both_cnt = 0;
   int         busy_cnt = 0;
   int         busy_at_dv = 0;

   uart_receiver dut (
      .clk       (clk),
      .reset     (reset),
      .RxD       (RxD),
      .RxData    (RxData),
      .dataValid (dataValid),
      .frameError(frameError),
      .isBusy    (isBusy)
   );

   always #5 clk = ~clk;

   // Output monitor sampled on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (dataValid) begin
         rx_q.push_back(RxData);
         dv_cyc.push_back(cyc);
         if (isBusy) busy_at_dv++;
      end
      if (frameError) fe_cnt++;
      if (dataValid && frameError) both_cnt++;
      if (isBusy) busy_cnt++;
   end

   task automatic clear_mon();
      rx_q.delete();
      dv_cyc.delete();
      fe_cnt = 0;
      both_cnt = 0;
      busy_cnt = 0;
      busy_at_dv = 0;
   endtask

   // Drives one frame starting now (caller is at a falling edge)
   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len);
      RxD = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         RxD = b[i];
         repeat (BIT) @(negedge clk);
      end
      RxD = stop_v;
      repeat (stop_len) @(negedge clk);
      RxD = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      RxD = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (RxData !== 8'h00) $display("FAIL reset_rxdata: got %h expected 00", RxData); else passed++;
      checks++; if (dataValid !== 1'b0) $display("FAIL reset_datavalid: got %b expected 0", dataValid); else passed++;
      checks++; if (frameError !== 1'b0) $display("FAIL reset_frameerror: got %b expected 0", frameError); else passed++;
      checks++; if (isBusy !== 1'b0) $display("FAIL reset_isbusy: got %b expected 0", isBusy); else passed++;
      reset = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_single_byte();
      clear_mon();
      send_frame(8'hA5, 1'b1, BIT);
      repeat (10) @(negedge clk);
      checks++; if (rx_q.size() !== 1) $display("FAIL a5_count: got %0d expected 1", rx_q.size()); else passed++;
      checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'hA5) $display("FAIL a5_data: got %h expected a5", rx_q[0]); else passed++;
      checks++; if (fe_cnt !== 0) $display("FAIL a5_frameerror: got %0d expected 0", fe_cnt); else passed++;
      checks++; if (busy_at_dv !== 0) $display("FAIL a5_busy_at_pulse: got %0d expected 0", busy_at_dv); else passed++;
      checks++; if (isBusy !== 1'b0) $display("FAIL a5_busy_after: got %b expected 0", isBusy); else passed++;
   endtask

   task automatic test_back_to_back();
      clear_mon();
      send_frame(8'h00, 1'b1, BIT);
      send_frame(8'hFF, 1'b1, BIT);
      repeat (10) @(negedge clk);
      checks++; if (rx_q.size() !== 2) $display("FAIL b2b_count: got %0d expected 2", rx_q.size()); else passed++;
      checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h00) $display("FAIL b2b_first: got %h expected 00", rx_q[0]); else passed++;
      checks++; if (rx_q.size() > 1 && rx_q[1] !== 8'hFF) $display("FAIL b2b_second: got %h expected ff", rx_q[1]); else passed++;
      checks++; if (dv_cyc.size() > 1 && (dv_cyc[1] - dv_cyc[0]) !== 280) $display("FAIL b2b_spacing: got %0d expected 280", dv_cyc[1] - dv_cyc[0]); else passed++;
      checks++; if (fe_cnt !== 0) $display("FAIL b2b_frameerror: got %0d expected 0", fe_cnt); else passed++;
   endtask

   task automatic test_glitch();
      clear_mon();
      RxD = 1'b0;
      repeat (5) @(negedge clk);
      RxD = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (rx_q.size() !== 0) $display("FAIL glitch_no_pulse: got %0d expected 0", rx_q.size()); else passed++;
      checks++; if (busy_cnt < 1 || busy_cnt > 16) $display("FAIL glitch_busy_len: got %0d expected 1..16", busy_cnt); else passed++;
      checks++; if (isBusy !== 1'b0) $display("FAIL glitch_busy_after: got %b expected 0", isBusy); else passed++;
      clear_mon();
      send_frame(8'h3C, 1'b1, BIT);
      repeat (10) @(negedge clk);
      checks++; if (rx_q.size() !== 1) $display("FAIL glitch_next_count: got %0d expected 1", rx_q.size()); else passed++;
      checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h3C) $display("FAIL glitch_next_data: got %h expected 3c", rx_q[0]); else passed++;
   endtask

   task automatic test_frame_error();
      clear_mon();
      send_frame(8'h5A, 1'b0, 100);
      checks++; if (fe_cnt !== 1) $display("FAIL fe_count: got %0d expected 1", fe_cnt); else passed++;
      checks++; if (rx_q.size() !== 0) $display("FAIL fe_no_valid: got %0d expected 0", rx_q.size()); else passed++;
      checks++; if (RxData !== 8'h3C) $display("FAIL fe_rxdata_held: got %h expected 3c", RxData); else passed++;
      checks++; if (isBusy !== 1'b1) $display("FAIL fe_busy_held: got %b expected 1", isBusy); else passed++;
      checks++; if (both_cnt !== 0) $display("FAIL fe_exclusive: got %0d expected 0", both_cnt); else passed++;
      repeat (5) @(negedge clk);
      checks++; if (isBusy !== 1'b0) $display("FAIL fe_busy_release: got %b expected 0", isBusy); else passed++;
      repeat (20) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      clear_mon();
      b = 8'h81;
      RxD = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         RxD = b[i];
         repeat (BIT) @(negedge clk);
      end
      RxD = b[4];
      repeat (BIT / 2) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++; if (RxData !== 8'h00) $display("FAIL midrst_rxdata: got %h expected 00", RxData); else passed++;
      checks++; if (dataValid !== 1'b0) $display("FAIL midrst_datavalid: got %b expected 0", dataValid); else passed++;
      checks++; if (frameError !== 1'b0) $display("FAIL midrst_frameerror: got %b expected 0", frameError); else passed++;
      checks++; if (isBusy !== 1'b0) $display("FAIL midrst_isbusy: got %b expected 0", isBusy); else passed++;
      @(negedge clk);
      RxD = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (60) @(negedge clk);
      send_frame(8'h7E, 1'b1, BIT);
      repeat (10) @(negedge clk);
      checks++; if (rx_q.size() !== 1) $display("FAIL midrst_count: got %0d expected 1", rx_q.size()); else passed++;
      checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h7E) $display("FAIL midrst_data: got %h expected 7e", rx_q[0]); else passed++;
      checks++; if (fe_cnt !== 0) $display("FAIL midrst_frameerror_cnt: got %0d expected 0", fe_cnt); else passed++;
   endtask

   task automatic test_loopback();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      clear_mon();
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_frame(b, 1'b1, BIT);
         repeat (2 * BIT) @(negedge clk);
      end
      repeat (10) @(negedge clk);
      checks++; if (rx_q.size() !== 16) $display("FAIL loop_count: got %0d expected 16", rx_q.size()); else passed++;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (i >= rx_q.size()) $display("FAIL loop_byte%0d: got none expected %h", i, exp_q[i]);
         else if (rx_q[i] !== exp_q[i]) $display("FAIL loop_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]);
         else passed++;
      end
      checks++; if (fe_cnt !== 0) $display("FAIL loop_frameerror: got %0d expected 0", fe_cnt); else passed++;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
      test_loopback();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
